// File: rtl/sprite_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_renderer_pkg
//  Description : Video geometry and colour constants shared by the scan
//                generator, sprite movement logic and sprite renderer.
//  Revision    : 1.0  initial release
// ============================================================================
package sprite_renderer_pkg;

  localparam int          c_SCREEN_W   = 640;
  localparam int          c_SCREEN_H   = 480;
  localparam int          c_SPRITE_W   = 32;
  localparam int          c_SPRITE_H   = 32;
  localparam int          c_RGB_W      = 12;
  localparam logic [11:0] c_TRANSP_KEY = 12'hF0F;
  localparam int          c_COORD_W    = 10;

  typedef logic [c_RGB_W-1:0]   rgb_t;
  typedef logic [c_COORD_W-1:0] coord_t;

endpackage : sprite_renderer_pkg
`default_nettype wire

// File: rtl/sprite_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_renderer_if
//  Description : Scan/position inputs, sprite ROM port and pixel outputs of
//                the sprite renderer. The master side is the scan/ROM/VGA
//                environment, the slave side is the renderer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface sprite_renderer_if #(
  parameter int ADDR_W = 10
);
  import sprite_renderer_pkg::*;

  logic              frame_start;
  coord_t            sprite_x;
  coord_t            sprite_y;
  coord_t            hcount;
  coord_t            vcount;
  logic              video_on;
  rgb_t              bg_rgb;
  logic [ADDR_W-1:0] rom_addr;
  rgb_t              rom_data;
  rgb_t              pixel_rgb;
  logic              pixel_on;
  logic              sprite_hit;

  modport master (
    output frame_start, sprite_x, sprite_y, hcount, vcount, video_on, bg_rgb,
    output rom_data,
    input  rom_addr, pixel_rgb, pixel_on, sprite_hit
  );

  modport slave (
    input  frame_start, sprite_x, sprite_y, hcount, vcount, video_on, bg_rgb,
    input  rom_data,
    output rom_addr, pixel_rgb, pixel_on, sprite_hit
  );

endinterface : sprite_renderer_if
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_renderer
//  Description : Overlays a 32x32 RGB444 sprite on the background. Latches
//                the sprite position once per frame, generates the sprite
//                ROM address, and selects texel or background two cycles
//                later when the synchronous ROM data is available.
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int          SPRITE_W   = c_SPRITE_W,
  parameter int          SPRITE_H   = c_SPRITE_H,
  parameter int          SCREEN_W   = c_SCREEN_W,
  parameter int          SCREEN_H   = c_SCREEN_H,
  parameter logic [11:0] TRANSP_KEY = c_TRANSP_KEY,
  parameter int          ADDR_W     = 10
) (
  input  wire logic         clk25,
  input  wire logic         rst_n,
  sprite_renderer_if.slave  bus
);

  localparam int unsigned c_XW = $clog2(SPRITE_W);
  localparam int unsigned c_YW = $clog2(SPRITE_H);

  // Geometry must fit the 10-bit scan counters and the ROM address split.
  if (SPRITE_W != (1 << c_XW) || SPRITE_H != (1 << c_YW) ||
      (c_XW + c_YW) != ADDR_W || SCREEN_W > 1023 || SCREEN_H > 1023) begin : g_cfg_check
    $error("sprite_renderer: inconsistent geometry parameters");
  end

  coord_t            r_lat_x;
  coord_t            r_lat_y;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit_d1, r_hit_d2;
  logic              r_vid_d1, r_vid_d2;
  rgb_t              r_bg_d1,  r_bg_d2;
  rgb_t              r_pixel_rgb;
  logic              r_pixel_on;
  logic              r_sprite_hit;

  logic [10:0]       w_x_end;
  logic [10:0]       w_y_end;
  logic              w_in_box;
  logic [c_XW-1:0]   w_off_x;
  logic [c_YW-1:0]   w_off_y;

  // Box edges are computed one bit wider so a sprite near 1023 cannot wrap
  // around and produce a false hit at the left/top of the screen.
  assign w_x_end  = {1'b0, r_lat_x} + 11'(SPRITE_W);
  assign w_y_end  = {1'b0, r_lat_y} + 11'(SPRITE_H);
  assign w_in_box = bus.video_on &&
                    (bus.hcount >= r_lat_x) && ({1'b0, bus.hcount} < w_x_end) &&
                    (bus.vcount >= r_lat_y) && ({1'b0, bus.vcount} < w_y_end);

  // Only the low bits of the offset matter; they are exact whenever in box.
  assign w_off_x = c_XW'(bus.hcount - r_lat_x);
  assign w_off_y = c_YW'(bus.vcount - r_lat_y);

  // Sprite position is taken only at frame start so moves never tear.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_x <= '0;
      r_lat_y <= '0;
    end else if (bus.frame_start) begin
      r_lat_x <= bus.sprite_x;
      r_lat_y <= bus.sprite_y;
    end
  end

  // Row-major texel address; held outside the box to avoid needless toggling.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
    end else if (w_in_box) begin
      r_rom_addr <= {w_off_y, w_off_x};
    end
  end

  // Two-stage delay of hit/video/background to meet the ROM read data.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_d1 <= 1'b0;
      r_hit_d2 <= 1'b0;
      r_vid_d1 <= 1'b0;
      r_vid_d2 <= 1'b0;
      r_bg_d1  <= '0;
      r_bg_d2  <= '0;
    end else begin
      r_hit_d1 <= w_in_box;
      r_hit_d2 <= r_hit_d1;
      r_vid_d1 <= bus.video_on;
      r_vid_d2 <= r_vid_d1;
      r_bg_d1  <= bus.bg_rgb;
      r_bg_d2  <= r_bg_d1;
    end
  end

  // Final colour select: blanking, opaque sprite texel, or background.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_rgb  <= '0;
      r_sprite_hit <= 1'b0;
      r_pixel_on   <= 1'b0;
    end else begin
      r_pixel_on <= r_vid_d2;
      if (!r_vid_d2) begin
        r_pixel_rgb  <= '0;
        r_sprite_hit <= 1'b0;
      end else if (r_hit_d2 && (bus.rom_data != TRANSP_KEY)) begin
        r_pixel_rgb  <= bus.rom_data;
        r_sprite_hit <= 1'b1;
      end else begin
        r_pixel_rgb  <= r_bg_d2;
        r_sprite_hit <= 1'b0;
      end
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.pixel_rgb  = r_pixel_rgb;
  assign bus.pixel_on   = r_pixel_on;
  assign bus.sprite_hit = r_sprite_hit;

endmodule : sprite_renderer
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_renderer
//  Description : Self-checking bench for sprite_renderer: directed vector
//                table, randomized scan traffic against a behavioural model,
//                and asynchronous reset in mid-scan.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_renderer;
  import sprite_renderer_pkg::*;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;

  sprite_renderer_if #(.ADDR_W(10)) bus ();

  sprite_renderer #(
    .SPRITE_W(32), .SPRITE_H(32), .SCREEN_W(640), .SCREEN_H(480),
    .TRANSP_KEY(12'hF0F), .ADDR_W(10)
  ) dut (
    .clk25 (clk25),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  // Texture memory beside the renderer: synchronous read, one cycle latency.
  logic [11:0] rom [0:1023];
  always @(posedge clk25) bus.rom_data <= rom[bus.rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        on;
    logic        hit;
  } px_t;

  px_t q[$];
  int  lx = 0, ly = 0;
  int  m_addr = 0;
  int  sx_cur = 0, sy_cur = 0;

  typedef struct {
    int fs, sx, sy, h, v, von, bg;
    int chk_addr, exp_addr;
    int exp_rgb, exp_hit, exp_on;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    px_t z;
    z.rgb = '0; z.on = 1'b0; z.hit = 1'b0;
    lx = 0; ly = 0; m_addr = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  // One pixel clock: apply inputs, predict from the sprite rules, clock,
  // then compare the address for this pixel and the pixel from two back.
  task automatic drive(input int fs, input int sx, input int sy, input int h,
                       input int v, input int von, input int bg);
    px_t e;
    int  a;
    bit  inb;
    bus.frame_start = fs[0];
    bus.sprite_x    = 10'(sx);
    bus.sprite_y    = 10'(sy);
    bus.hcount      = 10'(h);
    bus.vcount      = 10'(v);
    bus.video_on    = von[0];
    bus.bg_rgb      = 12'(bg);
    inb = (von != 0) && (h >= lx) && (h < lx + 32) && (v >= ly) && (v < ly + 32);
    a   = (((v - ly) & 31) * 32) + ((h - lx) & 31);
    if (inb) m_addr = a;
    e.on = (von != 0);
    if (von == 0) begin
      e.rgb = '0; e.hit = 1'b0;
    end else if (inb && rom[a] != 12'hF0F) begin
      e.rgb = rom[a]; e.hit = 1'b1;
    end else begin
      e.rgb = 12'(bg); e.hit = 1'b0;
    end
    q.push_back(e);
    if (fs != 0) begin
      lx = sx; ly = sy;
    end
    @(posedge clk25);
    #1;
    chk("model rom_addr", int'(bus.rom_addr), m_addr);
    e = q.pop_front();
    chk("model pixel_rgb", int'(bus.pixel_rgb), int'(e.rgb));
    chk("model pixel_on", int'(bus.pixel_on), int'(e.on));
    chk("model sprite_hit", int'(bus.sprite_hit), int'(e.hit));
  endtask

  task automatic random_cycles(input int n, input bit allow_fs);
    int fs, h, v, von, bg;
    for (int i = 0; i < n; i++) begin
      fs = 0;
      if (allow_fs && ($urandom % 40 == 0)) begin
        fs = 1;
        sx_cur = $urandom_range(0, 1023);
        sy_cur = $urandom_range(0, 1023);
        if ($urandom % 2) begin
          sx_cur = $urandom_range(0, 639);
          sy_cur = $urandom_range(0, 479);
        end
      end else if ($urandom % 60 == 0) begin
        sx_cur = $urandom_range(0, 700);
      end
      if ($urandom % 3 != 0) begin
        h = (lx + $urandom_range(0, 40) - 4) & 10'h3FF;
        v = (ly + $urandom_range(0, 40) - 4) & 10'h3FF;
      end else begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
      end
      von = ($urandom % 10 != 0) ? 1 : 0;
      bg  = $urandom_range(0, 4095);
      drive(fs, sx_cur, sy_cur, h, v, von, bg);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = 12'($urandom);
      if (rom[i] == 12'hF0F) rom[i] = 12'h000;
      if (i % 7 == 3) rom[i] = 12'hF0F;
    end
    rom[0]    = 12'h123;
    rom[1023] = 12'h456;
    rom[5]    = 12'hF0F;
    rom[6]    = 12'h0F0;
    rom[31]   = 12'h789;
    rom[339]  = 12'h9AB;

    //          fs  sx   sy  h    v   von bg       ca addr  rgb     hit on
    vecs = '{
      '{1, 100, 50,   0,  0, 0, 'hABC, 0, 0,    'h000, 0, 0},
      '{0, 100, 50, 100, 50, 1, 'h111, 1, 0,    'h123, 1, 1},
      '{0, 100, 50, 131, 81, 1, 'h111, 1, 1023, 'h456, 1, 1},
      '{0, 100, 50, 132, 81, 1, 'h222, 1, 1023, 'h222, 0, 1},
      '{0, 100, 50,  99, 50, 1, 'h333, 1, 1023, 'h333, 0, 1},
      '{0, 100, 50, 105, 50, 1, 'h444, 1, 5,    'h444, 0, 1},
      '{0, 100, 50, 106, 50, 1, 'h444, 1, 6,    'h0F0, 1, 1},
      '{0, 101, 50, 100, 50, 1, 'h555, 1, 0,    'h123, 1, 1},
      '{1, 101, 50, 100, 50, 1, 'h555, 1, 0,    'h123, 1, 1},
      '{0, 101, 50, 100, 50, 1, 'h666, 1, 0,    'h666, 0, 1},
      '{0, 101, 50, 132, 50, 1, 'h666, 1, 31,   'h789, 1, 1},
      '{1, 620, 50,   0,  0, 0, 'h000, 0, 0,    'h000, 0, 0},
      '{0, 620, 50, 619, 50, 1, 'h777, 1, 31,   'h777, 0, 1},
      '{0, 620, 50, 620, 50, 1, 'h777, 1, 0,    'h123, 1, 1},
      '{0, 620, 50, 639, 60, 1, 'h777, 1, 339,  'h9AB, 1, 1},
      '{1, 1000, 50,  0,  0, 0, 'h000, 0, 0,    'h000, 0, 0},
      '{0, 1000, 50,  0, 50, 1, 'h888, 1, 339,  'h888, 0, 1},
      '{0, 1000, 50,  7, 50, 1, 'h999, 1, 339,  'h999, 0, 1},
      '{1, 100, 50,   0,  0, 0, 'h000, 0, 0,    'h000, 0, 0},
      '{0, 100, 50, 100, 50, 0, 'hBBB, 1, 339,  'h000, 0, 0}
    };

    bus.frame_start = 1'b0;
    bus.sprite_x    = '0;
    bus.sprite_y    = '0;
    bus.hcount      = '0;
    bus.vcount      = '0;
    bus.video_on    = 1'b0;
    bus.bg_rgb      = '0;

    // Reset state.
    #1;
    chk("reset rom_addr", int'(bus.rom_addr), 0);
    chk("reset pixel_rgb", int'(bus.pixel_rgb), 0);
    chk("reset pixel_on", int'(bus.pixel_on), 0);
    chk("reset sprite_hit", int'(bus.sprite_hit), 0);
    repeat (2) @(posedge clk25);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Directed table: each vector followed by two blank cycles, then the
    // vector's own pixel is on the outputs.
    foreach (vecs[i]) begin
      drive(vecs[i].fs, vecs[i].sx, vecs[i].sy, vecs[i].h, vecs[i].v,
            vecs[i].von, vecs[i].bg);
      if (vecs[i].chk_addr != 0)
        chk($sformatf("vec%0d rom_addr", i), int'(bus.rom_addr), vecs[i].exp_addr);
      drive(0, vecs[i].sx, vecs[i].sy, 0, 0, 0, 0);
      drive(0, vecs[i].sx, vecs[i].sy, 0, 0, 0, 0);
      chk($sformatf("vec%0d pixel_rgb", i), int'(bus.pixel_rgb), vecs[i].exp_rgb);
      chk($sformatf("vec%0d sprite_hit", i), int'(bus.sprite_hit), vecs[i].exp_hit);
      chk($sformatf("vec%0d pixel_on", i), int'(bus.pixel_on), vecs[i].exp_on);
    end

    // Randomized traffic with frame_start pulses and mid-frame moves.
    sx_cur = 100; sy_cur = 50;
    random_cycles(800, 1'b1);

    // Asynchronous reset between clock edges in mid-scan.
    #5;
    rst_n = 1'b0;
    #1;
    chk("async rst rom_addr", int'(bus.rom_addr), 0);
    chk("async rst pixel_rgb", int'(bus.pixel_rgb), 0);
    chk("async rst pixel_on", int'(bus.pixel_on), 0);
    chk("async rst sprite_hit", int'(bus.sprite_hit), 0);
    model_reset();
    @(posedge clk25);
    #1;
    rst_n = 1'b1;

    // Position stays at 0,0 until a new frame_start, then normal traffic.
    random_cycles(200, 1'b0);
    random_cycles(800, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sprite_renderer
`default_nettype wire

// File: doc/sprite_renderer.md
# sprite_renderer

- Reads the sprite position produced by the sprite movement logic and the VGA scan coordinates.
- Fetches the matching texel from a 32x32 sprite ROM and outputs the final RGB444 pixel for the VGA output stage.
- Transparent texels and all pixels outside the sprite box pass the background colour.
- The sprite position is latched once per frame so a move never tears mid-frame.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- TRANSP_KEY, 12'hF0F, RGB444 colour treated as transparent
- ADDR_W, 10, ROM address width (log2(SPRITE_W*SPRITE_H))

Ports:
- clk25  in  1  pixel clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- sprite_x  in  10  sprite left edge, pixels
- sprite_y  in  10  sprite top edge, pixels
- hcount  in  10  current scan column
- vcount  in  10  current scan row
- video_on  in  1  scan position is in the visible area
- bg_rgb  in  12  background colour for this scan position
- rom_addr  out  ADDR_W  sprite ROM address, registered
- rom_data  in  12  ROM texel, valid one cycle after rom_addr (synchronous ROM)
- pixel_rgb  out  12  final pixel colour, registered
- pixel_on  out  1  video_on delayed to align with pixel_rgb
- sprite_hit  out  1  pixel_rgb came from an opaque sprite texel

## Operation
Position latch:
- On a frame_start pulse, lat_x <= sprite_x and lat_y <= sprite_y.
- lat_x and lat_y are held for the whole frame. The latch happens even if frame_start arrives while video_on=1.

Hit test (stage 0, combinational on inputs):
- in_box = video_on && hcount >= lat_x && hcount < lat_x+SPRITE_W && vcount >= lat_y && vcount < lat_y+SPRITE_H.
- The sums are evaluated at 11 bits so there is no wrap-around false hit.
- A latched position beyond the screen edge is legal; the sprite is then partially or fully clipped.

Address generation:
- off_x = (hcount - lat_x)[log2 W -1:0] and off_y = (vcount - lat_y)[log2 H -1:0].
- rom_addr <= {off_y, off_x} (row-major) when in_box; otherwise rom_addr holds its value.

Alignment:
- in_box, video_on and bg_rgb pass through two register stages (d1, d2) to line up with rom_data.

Output stage (stage 2):
- If !video_d2: pixel_rgb <= 0, sprite_hit <= 0.
- Else if hit_d2 && rom_data != TRANSP_KEY: pixel_rgb <= rom_data, sprite_hit <= 1.
- Else: pixel_rgb <= bg_d2, sprite_hit <= 0.
- pixel_on <= video_d2.

## Timing
- Latency: scan inputs sampled at edge N appear on pixel_rgb, pixel_on and sprite_hit after edge N+2.
  - Edge N: rom_addr registered.
  - Edge N+1: ROM output updated.
  - Edge N+2: outputs registered.
- Throughput: one pixel per clk25 cycle, no stalls.
- frame_start at edge N affects hit tests from edge N+1 onward.
- Reset (rst_n=0, asynchronous): rom_addr=0, pixel_rgb=0, pixel_on=0, sprite_hit=0, lat_x=0, lat_y=0, all pipeline flags 0.
- Reset mid-frame: pipeline contents are discarded. After release, the outputs are valid 2 cycles later, with lat_x and lat_y at 0 until the next frame_start.
- Simultaneous frame_start and an in-box pixel: that pixel uses the old latched position.

## Structure
- Shared package (video_pkg): SCREEN_W, SCREEN_H, SPRITE_W, SPRITE_H, TRANSP_KEY, and the RGB444 colour width constant. The scan generator and sprite logic already share these.
- One natural sub-module: sprite_rom (synchronous read ADDR_W x 12, initialised from a memory file). It is instantiated beside this block, not inside it, so the texture can be swapped.

## Test plan
- Reset, then frame_start with sprite_x=100, sprite_y=50. Scan (hcount=100, vcount=50): rom_addr=0 after 1 edge; pixel_rgb=rom[0], sprite_hit=1 after 2 edges.
- Same frame, scan (131, 81): rom_addr=1023. Scan (132, 81) and (99, 50): pixel_rgb=bg_rgb, sprite_hit=0.
- ROM texel = 12'hF0F inside the box: pixel_rgb=bg_rgb, sprite_hit=0. Texel = 12'h0F0: pixel_rgb=12'h0F0.
- sprite_x changes 100->101 mid-frame without frame_start: hit region stays at 100..131 until the next frame_start, then moves to 101..132.
- sprite_x=620 latched: hits only for hcount 620..639. sprite_x=1000: no hit at hcount 0..7 (no wrap).
- video_on=0 inside the box: pixel_rgb=0, pixel_on=0. Assert rst_n=0 mid-scan: all outputs read 0 immediately (asynchronous).
